mdu: RTL and testbench

- Multi-cycle multiply/divide unit for the MIPS32 execute stage. It handles the MULT/MULTU/DIV/DIVU work that the combinational ALU does not do, and owns the architectural HI/LO registers.
- The EX stage issues an operation with a start pulse and stalls the pipeline while busy is high.
- MFHI/MFLO read hi/lo directly. MTHI/MTLO write them through this block.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_divstep.sv | 33 +++
 rtl/mdu.sv | 160 ++++++++++++++++
 tb/tb_mdu.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared widths, op codes and FSM states for the multiply/divide unit
//
// Contents:
//   WORD_WIDTH, ZERO_WORD   operand / HI / LO width and its zero value
//   MDUOP_WIDTH, mdu_op_t   MDU operation codes issued by the EX stage
//   mdu_state_t             IDLE / CALC / FIN sequencing states
package mdu_pkg;

   localparam int WORD_WIDTH  = 32;
   localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
   localparam int MDUOP_WIDTH = 3;

   typedef enum logic [MDUOP_WIDTH-1:0] {
      MDU_NOP   = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_t;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIN  = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step
//
// Ports:
//   rem      in   W+1  partial remainder
//   quo      in   W    quotient register; unconsumed dividend bits sit in the MSBs
//   divisor  in   W    divisor magnitude
//   rem_nx   out  W+1  next partial remainder
//   quo_nx   out  W    next quotient register (new quotient bit shifted in at the LSB)
module mdu_divstep #(
   parameter int W = 32
) (
   input  logic [W:0]   rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W:0]   rem_nx,
   output logic [W-1:0] quo_nx
);

   logic [W:0]   shifted;
   logic [W+1:0] diff;
   logic         q_bit;

   always_comb begin
      // Bring down the next dividend bit, then try the subtraction one bit wider
      // so the borrow tells us whether to restore.
      shifted = {rem[W-1:0], quo[W-1]};
      diff    = {1'b0, shifted} - {2'b00, divisor};
      q_bit   = ~diff[W+1];
      rem_nx  = q_bit ? diff[W:0] : shifted;
      quo_nx  = {quo[W-2:0], q_bit};
   end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle MIPS32 multiply/divide unit owning the HI/LO registers
//
// Ports:
//   clk     in   1   clock, rising edge
//   rst     in   1   synchronous active-high reset
//   start   in   1   issue strobe, honoured only while idle
//   mdu_op  in   3   MDU_NOP/MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   op1     in   W   multiplicand / dividend / MTHI-MTLO data
//   op2     in   W   multiplier / divisor
//   flush   in   1   cancels any in-flight or same-cycle operation
//   busy    out  1   high while an iterative op is computing
//   done    out  1   one-cycle pulse, hi/lo already hold the new result
//   hi      out  W   HI register
//   lo      out  W   LO register
module mdu
   import mdu_pkg::*;
#(
   parameter int W     = WORD_WIDTH,
   parameter int CNT_W = $clog2(W) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [MDUOP_WIDTH-1:0] mdu_op,
   input  logic [W-1:0]           op1,
   input  logic [W-1:0]           op2,
   input  logic                   flush,
   output logic                   busy,
   output logic                   done,
   output logic [W-1:0]           hi,
   output logic [W-1:0]           lo
);

   mdu_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt;
   // p: upper accumulator (mult) or remainder (div); q: multiplier or
   // dividend/quotient; b: multiplicand or divisor. All hold magnitudes.
   logic [W:0]       p;
   logic [W-1:0]     q, b;
   logic             is_div, neg_q, neg_r;

   logic             signed_op, a_neg, b_neg, iter_op;
   logic [W-1:0]     a_mag, b_mag;
   logic [W:0]       mul_sum;
   logic [W:0]       div_rem_nx;
   logic [W-1:0]     div_quo_nx;
   logic [2*W-1:0]   prod_mag;

   mdu_divstep #(.W(W)) u_divstep (
      .rem     (p),
      .quo     (q),
      .divisor (b),
      .rem_nx  (div_rem_nx),
      .quo_nx  (div_quo_nx)
   );

   always_comb begin
      signed_op = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);
      iter_op   = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU) ||
                  (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);
      a_neg     = signed_op & op1[W-1];
      b_neg     = signed_op & op2[W-1];
      a_mag     = a_neg ? -op1 : op1;
      b_mag     = b_neg ? -op2 : op2;
      mul_sum   = {1'b0, p[W-1:0]} + (q[0] ? {1'b0, b} : {1'b0, ZERO_WORD});
      prod_mag  = {p[W-1:0], q};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= MDU_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         MDU_IDLE: if (start && iter_op) state_nx = MDU_CALC;
         MDU_CALC: begin
            busy = 1'b1;
            if (cnt == CNT_W'(W - 1)) state_nx = MDU_FIN;
         end
         MDU_FIN: begin
            busy     = 1'b1;
            state_nx = MDU_IDLE;
         end
         default: state_nx = MDU_IDLE;
      endcase
      if (flush) state_nx = MDU_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         p      <= '0;
         q      <= '0;
         b      <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         done   <= 1'b0;
         hi     <= ZERO_WORD;
         lo     <= ZERO_WORD;
      end else begin
         done <= 1'b0;
         if (!flush) begin
            case (state)
               MDU_IDLE: if (start) begin
                  case (mdu_op)
                     MDU_MULT, MDU_MULTU: begin
                        p      <= '0;
                        q      <= b_mag;
                        b      <= a_mag;
                        is_div <= 1'b0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= 1'b0;
                        cnt    <= '0;
                     end
                     MDU_DIV, MDU_DIVU: begin
                        p      <= '0;
                        q      <= a_mag;
                        b      <= b_mag;
                        is_div <= 1'b1;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        cnt    <= '0;
                     end
                     MDU_MTHI: hi <= op1;
                     MDU_MTLO: lo <= op1;
                     default: ;
                  endcase
               end
               MDU_CALC: begin
                  cnt <= cnt + 1'b1;
                  if (is_div) begin
                     p <= div_rem_nx;
                     q <= div_quo_nx;
                  end else begin
                     // Shift-right accumulator: the low product bit falls into q
                     // as the consumed multiplier bit leaves.
                     p <= {1'b0, mul_sum[W:1]};
                     q <= {mul_sum[0], q[W-1:1]};
                  end
               end
               MDU_FIN: begin
                  done <= 1'b1;
                  if (is_div) begin
                     lo <= neg_q ? -q : q;
                     hi <= neg_r ? -p[W-1:0] : p[W-1:0];
                  end else begin
                     {hi, lo} <= neg_q ? -prod_mag : prod_mag;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for the multiply/divide unit
module tb_mdu;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, flush, busy, done;
   logic [2:0]   mdu_op;
   logic [W-1:0] op1, op2, hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   mdu dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mdu_op (mdu_op),
      .op1    (op1),
      .op2    (op2),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue an op, optionally poke a stray start while busy, and check latency and result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input bit stray);
      int nb;
      bit got;
      @(negedge clk);
      mdu_op = op; op1 = a; op2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nb = 0;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            got = 1;
            break;
         end
         if (busy) nb++;
         if (stray && i == 4) begin
            start = 1'b1; mdu_op = MDU_MULTU; op1 = 32'd9; op2 = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, " done_seen"}, 64'(got), 64'd1);
      check({tag, " busy_cycles"}, 64'(nb), 64'(W + 1));
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      int ndone;
      rst = 1'b1; start = 1'b0; flush = 1'b0; mdu_op = MDU_NOP; op1 = '0; op2 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);

      run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      run_op("mult_minmin", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
      run_op("mult_neg3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      run_op("div_neg7by2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op("div_7byneg2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
      run_op("divu_100by7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1);
      run_op("divu_5by0", MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
      run_op("div_neg5by0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, 0);
      run_op("div_pos5by0", MDU_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
      run_op("div_min_by_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);

      // MTHI then MTLO on consecutive edges
      @(negedge clk);
      start = 1'b1; mdu_op = MDU_MTHI; op1 = 32'h1234;
      @(negedge clk);
      check("mthi hi", 64'(hi), 64'h1234);
      check("mthi busy", 64'(busy), 64'd0);
      check("mthi done", 64'(done), 64'd0);
      mdu_op = MDU_MTLO; op1 = 32'h5678;
      @(negedge clk);
      start = 1'b0;
      check("mtlo lo", 64'(lo), 64'h5678);
      check("mtlo hi", 64'(hi), 64'h1234);
      check("mtlo busy", 64'(busy), 64'd0);
      check("mtlo done", 64'(done), 64'd0);

      // Flush aborts an in-flight divide; a stray start while busy is ignored
      start = 1'b1; mdu_op = MDU_MTHI; op1 = 32'hAAAA;
      @(negedge clk);
      mdu_op = MDU_MTLO; op1 = 32'hBBBB;
      @(negedge clk);
      mdu_op = MDU_DIVU; op1 = 32'd100; op2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 1; i < 10; i++) begin
         if (done) ndone++;
         if (i == 5) begin
            start = 1'b1; mdu_op = MDU_MTHI; op1 = 32'hDEAD;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check("flush busy_before", 64'(busy), 64'd1);
      check("stray_start hi", 64'(hi), 64'hAAAA);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy_after", 64'(busy), 64'd0);
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("flush no_done", 64'(ndone), 64'd0);
      check("flush hi", 64'(hi), 64'hAAAA);
      check("flush lo", 64'(lo), 64'hBBBB);

      // Flush together with start: the MTHI must not land
      start = 1'b1; flush = 1'b1; mdu_op = MDU_MTHI; op1 = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start hi", 64'(hi), 64'hAAAA);
      check("flush_start busy", 64'(busy), 64'd0);

      // Reset mid-multiply
      start = 1'b1; mdu_op = MDU_MULT; op1 = 32'd5; op2 = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid busy", 64'(busy), 64'd0);
      check("rst_mid done", 64'(done), 64'd0);
      check("rst_mid hi", 64'(hi), 64'd0);
      check("rst_mid lo", 64'(lo), 64'd0);
      run_op("multu_3x4", MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
